// File: rtl/pc_select_unit_pkg.sv
// Shared definitions for the fetch PC generator: state encodings and
// default parameter values, also used by the trap unit.
package pc_select_unit_pkg;

  localparam int          PCSEL_ADDR_SIZE_DEF    = 32;
  localparam int          PCSEL_INST_BYTES_DEF   = 4;
  localparam int unsigned PCSEL_RESET_VECTOR_DEF = 32'h0000_0000;

  typedef enum logic {
    PCSEL_BOOT = 1'b0,
    PCSEL_RUN  = 1'b1
  } pcsel_state_t;

  // Index width for a redirect source number; at least one bit.
  function automatic int pcsel_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_select_unit_redirect_arbiter.sv
// Combinational priority encoder over the redirect sources.
// Source 0 has the highest priority.
module pc_redirect_arbiter
  import pc_select_unit_pkg::*;
#(
  parameter int ADDR_SIZE = PCSEL_ADDR_SIZE_DEF,
  parameter int NUM_REDIR = 4,
  parameter int IDX_W     = pcsel_idx_w(NUM_REDIR)
) (
  input  logic [NUM_REDIR-1:0]           redirValid,
  input  logic [NUM_REDIR*ADDR_SIZE-1:0] redirAddr,
  output logic                           hit,
  output logic [IDX_W-1:0]               newIdx,
  output logic [ADDR_SIZE-1:0]           newAddr
);

  logic [ADDR_SIZE-1:0] w_addr [NUM_REDIR];

  // Split the flat address bus into one entry per source.
  generate
    for (genvar gi = 0; gi < NUM_REDIR; gi++) begin : g_unpack
      assign w_addr[gi] = redirAddr[gi*ADDR_SIZE +: ADDR_SIZE];
    end
  endgenerate

  // Scan from the lowest priority upwards so the lowest requesting index wins.
  always_comb begin
    hit     = 1'b0;
    newIdx  = '0;
    newAddr = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redirValid[i]) begin
        hit     = 1'b1;
        newIdx  = IDX_W'(i);
        newAddr = w_addr[i];
      end
    end
  end

endmodule

// File: rtl/pc_select_unit.sv
// Fetch PC generator: sequential increment or prioritised redirect,
// presented to fetch over valid/ready, with redirects latched across stalls.
module pc_select_unit
  import pc_select_unit_pkg::*;
#(
  parameter int                   ADDR_SIZE    = PCSEL_ADDR_SIZE_DEF,
  parameter int                   NUM_REDIR    = 4,
  parameter int                   INST_BYTES   = PCSEL_INST_BYTES_DEF,
  parameter logic [ADDR_SIZE-1:0] RESET_VECTOR = ADDR_SIZE'(PCSEL_RESET_VECTOR_DEF)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_REDIR-1:0]           redirValid,
  input  logic [NUM_REDIR*ADDR_SIZE-1:0] redirAddr,
  input  logic                           fetchReady,
  output logic                           fetchValid,
  output logic [ADDR_SIZE-1:0]           pc,
  output logic                           pcMisaligned,
  output logic                           redirPending
);

  localparam int IDX_W = pcsel_idx_w(NUM_REDIR);
  localparam int OFF_W = $clog2(INST_BYTES);

  pcsel_state_t         r_state;
  logic [ADDR_SIZE-1:0] r_pc;
  logic                 r_pend_valid;
  logic [IDX_W-1:0]     r_pend_idx;
  logic [ADDR_SIZE-1:0] r_pend_addr;

  logic                 w_hit;
  logic [IDX_W-1:0]     w_new_idx;
  logic [ADDR_SIZE-1:0] w_new_addr;
  logic                 w_new_wins;
  logic                 w_eff_valid;
  logic [ADDR_SIZE-1:0] w_eff_addr;
  logic                 w_accept;

  pc_redirect_arbiter #(
    .ADDR_SIZE (ADDR_SIZE),
    .NUM_REDIR (NUM_REDIR),
    .IDX_W     (IDX_W)
  ) u_arb (
    .redirValid (redirValid),
    .redirAddr  (redirAddr),
    .hit        (w_hit),
    .newIdx     (w_new_idx),
    .newAddr    (w_new_addr)
  );

  // A new request beats the latched one when it is of equal or higher
  // priority; on a tie the newer request is the more recent intent.
  assign w_new_wins  = w_hit && (!r_pend_valid || (w_new_idx <= r_pend_idx));
  assign w_eff_valid = w_new_wins || r_pend_valid;
  assign w_eff_addr  = w_new_wins ? w_new_addr : r_pend_addr;
  assign w_accept    = fetchValid && fetchReady;

  assign fetchValid   = (r_state == PCSEL_RUN);
  assign pc           = r_pc;
  assign pcMisaligned = |r_pc[OFF_W-1:0];
  assign redirPending = r_pend_valid;

  // State, PC and pending-redirect update; pc only moves on a handshake so
  // it stays stable while fetch is stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= PCSEL_BOOT;
      r_pc         <= RESET_VECTOR;
      r_pend_valid <= 1'b0;
      r_pend_idx   <= '0;
      r_pend_addr  <= '0;
    end else if (r_state == PCSEL_BOOT) begin
      // Leaving BOOT keeps the reset vector; early redirects wait in pending.
      r_state <= PCSEL_RUN;
      if (w_new_wins) begin
        r_pend_valid <= 1'b1;
        r_pend_idx   <= w_new_idx;
        r_pend_addr  <= w_new_addr;
      end
    end else if (w_accept) begin
      if (w_eff_valid) begin
        r_pc         <= w_eff_addr;
        r_pend_valid <= 1'b0;
      end else begin
        r_pc <= r_pc + ADDR_SIZE'(INST_BYTES);
      end
    end else if (w_new_wins) begin
      r_pend_valid <= 1'b1;
      r_pend_idx   <= w_new_idx;
      r_pend_addr  <= w_new_addr;
    end
  end

endmodule

// File: tb/tb_pc_select_unit.sv
// Scoreboard bench for pc_select_unit: stimulus pushes the expected visible
// state, a negedge monitor pops and compares.
module tb_pc_select_unit;

  localparam int          AW = 32;
  localparam int          NR = 4;
  localparam int          IB = 4;
  localparam logic [31:0] RV = 32'h0000_0100;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NR-1:0]     redirValid = '0;
  logic [NR*AW-1:0]  redirAddr = '0;
  logic              fetchReady = 1'b0;
  logic              fetchValid;
  logic [AW-1:0]     pc;
  logic              pcMisaligned;
  logic              redirPending;

  pc_select_unit #(
    .ADDR_SIZE    (AW),
    .NUM_REDIR    (NR),
    .INST_BYTES   (IB),
    .RESET_VECTOR (RV)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .redirValid   (redirValid),
    .redirAddr    (redirAddr),
    .fetchReady   (fetchReady),
    .fetchValid   (fetchValid),
    .pc           (pc),
    .pcMisaligned (pcMisaligned),
    .redirPending (redirPending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        pend;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  // Reference model: architectural PC, run flag and the waiting redirect.
  bit          m_run = 1'b0;
  logic [31:0] m_pc = RV;
  bit          m_pv = 1'b0;
  int          m_pi = 0;
  logic [31:0] m_pa = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [NR*AW-1:0] addrs(input logic [31:0] a0, input logic [31:0] a1,
                                             input logic [31:0] a2, input logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_pc  = RV;
    m_pv  = 1'b0;
    m_pi  = 0;
    m_pa  = '0;
  endtask

  // Apply one clock edge of the specified behaviour to the model.
  task automatic model_step(input logic [NR-1:0] v, input logic [NR*AW-1:0] a, input logic r);
    int          w;
    bit          beats;
    logic [31:0] wa;
    if (!rstn) begin
      model_reset();
      return;
    end
    w = -1;
    for (int i = 0; i < NR; i++)
      if (v[i] && w < 0) w = i;
    wa    = (w >= 0) ? a[w*AW +: AW] : 32'h0;
    beats = (w >= 0) && (!m_pv || w <= m_pi);
    if (!m_run) begin
      if (beats) begin m_pv = 1'b1; m_pi = w; m_pa = wa; end
      m_run = 1'b1;
    end else if (r) begin
      if (beats)     begin m_pc = wa;   m_pv = 1'b0; end
      else if (m_pv) begin m_pc = m_pa; m_pv = 1'b0; end
      else                 m_pc = m_pc + 32'd4;
    end else if (beats) begin
      m_pv = 1'b1; m_pi = w; m_pa = wa;
    end
  endtask

  // Called at posedge+1: record what the DUT shows now, drive this cycle's
  // inputs, advance the model across the coming edge.
  task automatic cycle(input logic [NR-1:0] v, input logic [NR*AW-1:0] a, input logic r);
    exp_q.push_back('{m_pc, m_run, m_pv, (m_pc[1:0] != 2'b00)});
    redirValid = v;
    redirAddr  = a;
    fetchReady = r;
    model_step(v, a, r);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare visible outputs against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      txn++;
      $display("txn %0d pc=%h fv=%b pend=%b mis=%b exp_pc=%h", txn, pc, fetchValid,
               redirPending, pcMisaligned, e.pc);
      check("pc", pc, e.pc);
      check("fetchValid", {31'b0, fetchValid}, {31'b0, e.fv});
      check("redirPending", {31'b0, redirPending}, {31'b0, e.pend});
      check("pcMisaligned", {31'b0, pcMisaligned}, {31'b0, e.mis});
    end
  end

  initial begin
    logic [NR-1:0]    rv;
    logic [NR*AW-1:0] ra;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Boot and plain sequencing from the reset vector.
    repeat (4) cycle('0, '0, 1'b1);

    // Redirect on accept: reach 0x200, then source 2 -> 0x400.
    cycle(4'b0001, addrs(32'h200, 0, 0, 0), 1'b1);
    cycle(4'b0100, addrs(0, 0, 32'h400, 0), 1'b1);
    cycle('0, '0, 1'b1);

    // Stall capture at 0x300.
    cycle(4'b0001, addrs(32'h300, 0, 0, 0), 1'b1);
    cycle(4'b0100, addrs(0, 0, 32'h500, 0), 1'b0);
    cycle(4'b0010, addrs(0, 32'h600, 0, 0), 1'b0);
    cycle(4'b1000, addrs(0, 0, 0, 32'h700), 1'b0);
    cycle('0, '0, 1'b0);
    cycle('0, '0, 1'b1);
    cycle('0, '0, 1'b1);

    // Simultaneous requests, then equal-priority newer request wins.
    cycle(4'b1011, addrs(32'h800, 32'h900, 0, 32'hA00), 1'b1);
    cycle(4'b0001, addrs(32'hB00, 0, 0, 0), 1'b0);
    cycle(4'b0001, addrs(32'hC00, 0, 0, 0), 1'b1);
    cycle('0, '0, 1'b1);

    // Wrap-around and misaligned target.
    cycle(4'b0001, addrs(32'hFFFF_FFFC, 0, 0, 0), 1'b1);
    cycle('0, '0, 1'b1);
    cycle(4'b0001, addrs(32'h1002, 0, 0, 0), 1'b1);
    cycle('0, '0, 1'b1);
    cycle('0, '0, 1'b1);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      rv = ($urandom_range(0, 2) == 0) ? NR'($urandom) : '0;
      for (int s = 0; s < NR; s++) begin
        logic [31:0] x;
        x = $urandom;
        if ($urandom_range(0, 7) != 0) x[1:0] = 2'b00;
        ra[s*AW +: AW] = x;
      end
      cycle(rv, ra, ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset while a redirect is pending.
    cycle(4'b0100, addrs(0, 0, 32'h2000, 0), 1'b0);
    cycle('0, '0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    check("async_pc", pc, RV);
    check("async_pending", {31'b0, redirPending}, 32'd0);
    check("async_fetchValid", {31'b0, fetchValid}, 32'd0);
    model_reset();
    cycle('0, '0, 1'b1);
    cycle('0, '0, 1'b1);
    rstn = 1'b1;
    repeat (3) cycle('0, '0, 1'b1);

    @(negedge clk);
    #1;
    check("scoreboard_drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
